// File: rtl/matrix_uart_dumper.sv
// matrix_uart_dumper
//   Reads an m x n matrix of 32-bit words from a synchronous storage port
//   (row-major, address = base + r*n + c, wrapping at 256). Each element is
//   printed as unsigned decimal ASCII of bits [7:0], or '#' if any of bits
//   [31:8] are set. Elements in a row are separated by a space, and each row
//   ends with CR LF. The text is sent on an 8N1 UART line.
//   A one-byte holding register sits in front of the serialiser. This lets the
//   controller fetch and convert the next element while the current byte is
//   still on the line, so bytes leave back-to-back.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   i_start      one-cycle dump request
//   i_base_addr  storage address of element (0,0)
//   i_m, i_n     row / column count, legal 1..5
//   o_rd_addr    storage read address
//   i_rd_data    storage read data, valid one cycle after o_rd_addr
//   o_busy       high while a dump is in progress
//   o_done       one-cycle pulse after the final LF stop bit
//   o_err        one-cycle pulse after a rejected start
//   uart_tx      serial line, idle high
module matrix_uart_dumper #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_base_addr,
  input  logic [2:0]  i_m,
  input  logic [2:0]  i_n,
  output logic [7:0]  o_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        uart_tx
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int CYC_W   = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    READ     = 4'd1,
    WAIT     = 4'd2,
    CONV     = 4'd3,
    SEND_DIG = 4'd4,
    SEND_SEP = 4'd5,
    SEND_CR  = 4'd6,
    SEND_LF  = 4'd7,
    DONE     = 4'd8
  } state_e;

  state_e state_q, state_d;

  // Controller / datapath registers
  logic [2:0]       m_q, m_d, n_q, n_d, row_q, row_d, col_q, col_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       val_q, val_d;
  logic             hash_q, hash_d;
  logic [1:0]       hund_q, hund_d;
  logic [3:0]       tens_q, tens_d;
  logic [1:0]       dig_idx_q, dig_idx_d;
  logic             lf_sent_q, lf_sent_d;
  // Holding register and serialiser
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [8:0]       frame_q, frame_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             tx_active_q, tx_active_d;
  logic             tx_q, tx_d;
  // Registered status outputs
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic             start_ok_s;
  logic             tx_last_s;
  logic             tx_take_s;
  logic             load_s;
  logic [7:0]       load_byte_s;
  logic [1:0]       num_dig_s;
  logic [7:0]       dig_byte_s;

  assign start_ok_s = (i_m != 3'd0) && (i_m <= 3'd5) && (i_n != 3'd0) && (i_n <= 3'd5);
  // Last clock of the stop bit of the byte on the line
  assign tx_last_s  = tx_active_q && (bit_idx_q == 4'd9) && (cyc_q == CYC_LAST);
  // Serialiser takes the held byte when idle or exactly as the current byte ends
  assign tx_take_s  = hold_full_q && (!tx_active_q || tx_last_s);

  // Digit count and ASCII byte for the current digit position
  always_comb begin
    num_dig_s  = 2'd1;
    dig_byte_s = 8'h30;
    if (hash_q) begin
      num_dig_s  = 2'd1;
      dig_byte_s = 8'h23;
    end else if (hund_q != 2'd0) begin
      num_dig_s = 2'd3;
      case (dig_idx_q)
        2'd0:    dig_byte_s = {6'd0, hund_q} + 8'h30;
        2'd1:    dig_byte_s = {4'd0, tens_q} + 8'h30;
        default: dig_byte_s = val_q + 8'h30;
      endcase
    end else if (tens_q != 4'd0) begin
      num_dig_s = 2'd2;
      case (dig_idx_q)
        2'd0:    dig_byte_s = {4'd0, tens_q} + 8'h30;
        default: dig_byte_s = val_q + 8'h30;
      endcase
    end else begin
      num_dig_s  = 2'd1;
      dig_byte_s = val_q + 8'h30;
    end
  end

  // Next-state logic: controller FSM, holding register, serialiser, status
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    n_d         = n_q;
    row_d       = row_q;
    col_d       = col_q;
    addr_d      = addr_q;
    val_d       = val_q;
    hash_d      = hash_q;
    hund_d      = hund_q;
    tens_d      = tens_q;
    dig_idx_d   = dig_idx_q;
    lf_sent_d   = lf_sent_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    frame_d     = frame_q;
    bit_idx_d   = bit_idx_q;
    cyc_d       = cyc_q;
    tx_active_d = tx_active_q;
    tx_d        = tx_q;
    err_d       = 1'b0;
    load_s      = 1'b0;
    load_byte_s = 8'h00;

    case (state_q)
      IDLE: begin
        if (i_start && start_ok_s) begin
          state_d   = READ;
          m_d       = i_m;
          n_d       = i_n;
          addr_d    = i_base_addr;
          row_d     = 3'd0;
          col_d     = 3'd0;
          lf_sent_d = 1'b0;
        end else if (i_start) begin
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        val_d   = i_rd_data[7:0];
        hash_d  = |i_rd_data[31:8];
        hund_d  = 2'd0;
        tens_d  = 4'd0;
        state_d = CONV;
      end
      // One subtraction per cycle: hundreds first, then tens
      CONV: begin
        if (hash_q) begin
          dig_idx_d = 2'd0;
          state_d   = SEND_DIG;
        end else if (val_q >= 8'd100) begin
          val_d  = val_q - 8'd100;
          hund_d = hund_q + 2'd1;
        end else if (val_q >= 8'd10) begin
          val_d  = val_q - 8'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          dig_idx_d = 2'd0;
          state_d   = SEND_DIG;
        end
      end
      SEND_DIG: begin
        if (!hold_full_q) begin
          load_s      = 1'b1;
          load_byte_s = dig_byte_s;
          if (dig_idx_q == (num_dig_s - 2'd1)) begin
            dig_idx_d = 2'd0;
            state_d   = (col_q == (n_q - 3'd1)) ? SEND_CR : SEND_SEP;
          end else begin
            dig_idx_d = dig_idx_q + 2'd1;
          end
        end else begin
          state_d = SEND_DIG;
        end
      end
      SEND_SEP: begin
        if (!hold_full_q) begin
          load_s      = 1'b1;
          load_byte_s = 8'h20;
          col_d       = col_q + 3'd1;
          addr_d      = addr_q + 8'd1;
          state_d     = READ;
        end else begin
          state_d = SEND_SEP;
        end
      end
      SEND_CR: begin
        if (!hold_full_q) begin
          load_s      = 1'b1;
          load_byte_s = 8'h0D;
          state_d     = SEND_LF;
        end else begin
          state_d = SEND_CR;
        end
      end
      // After the final LF is queued, wait for its stop bit to end
      SEND_LF: begin
        if (!lf_sent_q) begin
          if (!hold_full_q) begin
            load_s      = 1'b1;
            load_byte_s = 8'h0A;
            col_d       = 3'd0;
            if (row_q != (m_q - 3'd1)) begin
              row_d   = row_q + 3'd1;
              addr_d  = addr_q + 8'd1;
              state_d = READ;
            end else begin
              lf_sent_d = 1'b1;
            end
          end else begin
            state_d = SEND_LF;
          end
        end else if (!hold_full_q && tx_last_s) begin
          state_d = DONE;
        end else begin
          state_d = SEND_LF;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    hold_full_d = hold_full_q && !tx_take_s;
    if (load_s) begin
      hold_full_d = 1'b1;
      hold_d      = load_byte_s;
    end else begin
      hold_d = hold_q;
    end

    // frame_q holds the bits still to send after the current one (stop at MSB)
    if (tx_take_s) begin
      frame_d     = {1'b1, hold_q};
      tx_d        = 1'b0;
      bit_idx_d   = 4'd0;
      cyc_d       = '0;
      tx_active_d = 1'b1;
    end else if (tx_active_q) begin
      if (cyc_q == CYC_LAST) begin
        cyc_d = '0;
        if (bit_idx_q == 4'd9) begin
          tx_active_d = 1'b0;
          tx_d        = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 4'd1;
          tx_d      = frame_q[0];
          frame_d   = {1'b1, frame_q[8:1]};
        end
      end else begin
        cyc_d = cyc_q + CYC_W'(1);
      end
    end else begin
      tx_d = 1'b1;
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, serialiser and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q         <= 3'd0;
      n_q         <= 3'd0;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      addr_q      <= 8'h00;
      val_q       <= 8'h00;
      hash_q      <= 1'b0;
      hund_q      <= 2'd0;
      tens_q      <= 4'd0;
      dig_idx_q   <= 2'd0;
      lf_sent_q   <= 1'b0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      frame_q     <= 9'h1FF;
      bit_idx_q   <= 4'd0;
      cyc_q       <= '0;
      tx_active_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      m_q         <= m_d;
      n_q         <= n_d;
      row_q       <= row_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      val_q       <= val_d;
      hash_q      <= hash_d;
      hund_q      <= hund_d;
      tens_q      <= tens_d;
      dig_idx_q   <= dig_idx_d;
      lf_sent_q   <= lf_sent_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      frame_q     <= frame_d;
      bit_idx_q   <= bit_idx_d;
      cyc_q       <= cyc_d;
      tx_active_q <= tx_active_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign o_rd_addr = addr_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_err     = err_q;
  assign uart_tx   = tx_q;

endmodule

// File: doc/matrix_uart_dumper.md
MATRIX_UART_DUMPER -- requirements
Module: matrix_uart_dumper

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning UART line rate; bit period BIT_CYC = CLK_FREQ/BAUD (integer division, 868 at defaults).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_start  input  1  one-cycle request to dump a matrix.
REQ-006 SHALL have port i_base_addr  input  8  storage address of element (0,0).
REQ-007 SHALL have port i_m  input  3  row count, legal range 1..5.
REQ-008 SHALL have port i_n  input  3  column count, legal range 1..5.
REQ-009 SHALL have port o_rd_addr  output  8  storage read address.
REQ-010 SHALL have port i_rd_data  input  32  storage read data, valid exactly one cycle after o_rd_addr is presented.
REQ-011 SHALL have port o_busy  output  1  high from accepted start until done.
REQ-012 SHALL have port o_done  output  1  one-cycle pulse after the last byte's stop bit.
REQ-013 SHALL have port o_err  output  1  one-cycle pulse on a rejected start.
REQ-014 SHALL have port uart_tx  output  1  serial line, idle high.

Function
REQ-015 SHALL latch i_base_addr, i_m and i_n on an accepted i_start; later input changes have no effect on the dump in progress.
REQ-016 SHALL ignore i_start while o_busy=1, with no error pulse.
REQ-017 SHALL reject i_start when i_m or i_n is 0 or greater than 5: o_err pulses the following cycle, no bytes are sent, and o_busy stays 0.
REQ-018 SHALL read elements in row-major order from address base + r*n + c, computed modulo 256 (0xFF wraps to 0x00).
REQ-019 SHALL hold o_rd_addr stable for at least the read cycle and sample i_rd_data exactly one cycle later.
REQ-020 SHALL format an element as unsigned decimal ASCII of bits [7:0] with leading zeros suppressed; value 0 prints as '0'.
REQ-021 SHALL print a single '#' (0x23) when any of bits [31:8] are nonzero.
REQ-022 SHALL derive decimal digits by sequential subtraction of 100 then 10 (no divider), completing before the element's first byte is started.
REQ-023 SHALL separate elements within a row by one space (0x20), with no trailing space; each row ends with CR (0x0D) then LF (0x0A).
REQ-024 SHALL use controller FSM states IDLE, READ, WAIT, CONV, SEND_DIG, SEND_SEP, SEND_CR, SEND_LF, DONE.
REQ-025 SHALL follow these transitions: IDLE->READ on a valid start; READ->WAIT->CONV; CONV->SEND_DIG; after the last digit go to SEND_SEP if not the last column, else SEND_CR; SEND_SEP->READ; SEND_CR->SEND_LF; SEND_LF goes to READ if rows remain, else DONE; DONE->IDLE after one cycle with o_done=1.
REQ-026 SHALL transmit each byte as 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit held for exactly BIT_CYC cycles.
REQ-027 SHALL send bytes back-to-back with no idle gap beyond one clock cycle between a stop bit and the next start bit.
REQ-028 SHALL raise o_done in the cycle after the final LF's stop bit completes; o_busy falls in the same cycle.

Reset
REQ-029 SHALL, while rst=1, force uart_tx=1, o_busy=0, o_done=0, o_err=0, o_rd_addr=0x00, FSM=IDLE, and clear all counters.
REQ-030 SHALL abort a dump in progress when rst asserts; uart_tx is high on the cycle following the reset edge, and the partial byte is not resumed.
REQ-031 SHALL give rst priority over a simultaneous i_start.

Verification
REQ-032 SHALL pass: 1x1 matrix, base 0x10, mem[0x10]=7 -> bytes 0x37 0x0D 0x0A, then one o_done pulse.
REQ-033 SHALL pass: 2x3 matrix, base 0x00, data 0,9,10 / 99,100,255 -> text "0 9 10\r\n99 100 255\r\n"; read addresses 0..5 in order.
REQ-034 SHALL pass: element 0x00000100 -> '#'; base 0xFE with a 1x3 matrix -> reads 0xFE, 0xFF, 0x00.
REQ-035 SHALL pass: start with i_m=0 and start with i_n=6 -> o_err pulse each, uart_tx constantly 1, o_busy 0.
REQ-036 SHALL pass: rst asserted mid data bit of the second byte -> uart_tx=1 the next cycle, o_busy=0, no o_done; a new start then produces a complete, correct frame.
REQ-037 SHALL pass: measured bit width of 868 cycles +/-0 at defaults; a second i_start during busy leaves the output byte stream unchanged.
